// File: rtl/floor_scroller_pkg.sv
// Shared definitions for the floor playfield: screen geometry, initial layout,
// scroller FSM encoding and helpers for the packed 3x10-bit renderer buses.
package floor_scroller_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int NUM_FLOORS = 3;
    localparam int COORD_W    = 10;
    localparam int INIT_GAP_W = 64;

    typedef logic [COORD_W-1:0]            coord_t;
    typedef logic [NUM_FLOORS*COORD_W-1:0] floor_bus_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE0,
        ST_MOVE1,
        ST_MOVE2,
        ST_DONE
    } state_e;

    // Floors start evenly spaced, floor0 highest on screen.
    function automatic coord_t init_y(input int idx, input int spacing);
        return coord_t'((idx + 1) * spacing);
    endfunction

    function automatic coord_t init_gap_pos(input int idx);
        case (idx)
            0:       return coord_t'(64);
            1:       return coord_t'(288);
            default: return coord_t'(448);
        endcase
    endfunction

    // Renderer bus packing: floor0 in the low field.
    function automatic floor_bus_t pack3(input coord_t f0, input coord_t f1, input coord_t f2);
        return {f2, f1, f0};
    endfunction

endpackage

// File: rtl/floor_scroller_gap_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying the random
// gap position and width selector for respawned floors.
module gap_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [8:0] pos_o,
    output logic [3:0] width_sel_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = en_i ? {lfsr_q[14:0], feedback} : lfsr_q;
    end

    // A maximal-length sequence from a non-zero seed never reaches all-zeros.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign pos_o       = lfsr_q[8:0];
    assign width_sel_o = lfsr_q[13:10];

endmodule

// File: rtl/floor_scroller.sv
// Scrolls the three floors upward once per frame, one floor per cycle, and
// respawns a floor at the bottom with a random gap when it leaves the top.
module floor_scroller
    import floor_scroller_pkg::*;
#(
    parameter int          FLOOR_SPACING = 160,
    parameter int          MIN_GAP       = 48,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        restart,
    input  logic [2:0]  speed,
    output logic [29:0] yPos,
    output logic [29:0] gapsPos,
    output logic [29:0] gapsWidth,
    output logic        busy,
    output logic        step_done,
    output logic        floor_wrap
);

    localparam coord_t SPAN = coord_t'(NUM_FLOORS * FLOOR_SPACING);

    state_e     state_q, state_d;
    logic [2:0] spd_q, spd_d;
    coord_t     y_q    [NUM_FLOORS];
    coord_t     y_d    [NUM_FLOORS];
    coord_t     gpos_q [NUM_FLOORS];
    coord_t     gpos_d [NUM_FLOORS];
    coord_t     gw_q   [NUM_FLOORS];
    coord_t     gw_d   [NUM_FLOORS];
    logic       wrap_q, wrap_d;

    logic [8:0] rnd_pos;
    logic [3:0] rnd_wsel;
    logic [1:0] move_idx;
    logic       move_en;
    coord_t     cur_y;
    coord_t     spd_ext;

    gap_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .en_i        (1'b1),
        .pos_o       (rnd_pos),
        .width_sel_o (rnd_wsel)
    );

    // One shared update datapath; the MOVE state selects which floor it serves.
    always_comb begin
        move_idx = 2'd0;
        move_en  = 1'b0;
        case (state_q)
            ST_MOVE0: begin move_idx = 2'd0; move_en = 1'b1; end
            ST_MOVE1: begin move_idx = 2'd1; move_en = 1'b1; end
            ST_MOVE2: begin move_idx = 2'd2; move_en = 1'b1; end
            default:  ;
        endcase
    end

    assign cur_y   = y_q[move_idx];
    assign spd_ext = {7'd0, spd_q};

    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        spd_d   = spd_q;
        y_d     = y_q;
        gpos_d  = gpos_q;
        gw_d    = gw_q;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && run) begin
                    state_d = ST_MOVE0;
                    spd_d   = speed;
                end
            end
            ST_MOVE0: state_d = ST_MOVE1;
            ST_MOVE1: state_d = ST_MOVE2;
            ST_MOVE2: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (move_en) begin
            if (cur_y >= spd_ext) begin
                y_d[move_idx] = cur_y - spd_ext;
            end else begin
                // Wrapped value is at most 479, and the widest gap ends at 619 < 640.
                y_d[move_idx]    = cur_y + SPAN - spd_ext;
                gpos_d[move_idx] = {1'b0, rnd_pos};
                gw_d[move_idx]   = coord_t'(MIN_GAP) + {4'd0, rnd_wsel, 2'b00};
                wrap_d           = 1'b1;
            end
        end

        if (restart) begin
            state_d = ST_IDLE;
            wrap_d  = 1'b0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                y_d[i]    = init_y(i, FLOOR_SPACING);
                gpos_d[i] = init_gap_pos(i);
                gw_d[i]   = coord_t'(INIT_GAP_W);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            spd_q   <= 3'd0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                y_q[i]    <= init_y(i, FLOOR_SPACING);
                gpos_q[i] <= init_gap_pos(i);
                gw_q[i]   <= coord_t'(INIT_GAP_W);
            end
        end else begin
            state_q <= state_d;
            spd_q   <= spd_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
            gpos_q  <= gpos_d;
            gw_q    <= gw_d;
        end
    end

    assign yPos       = pack3(y_q[0], y_q[1], y_q[2]);
    assign gapsPos    = pack3(gpos_q[0], gpos_q[1], gpos_q[2]);
    assign gapsWidth  = pack3(gw_q[0], gw_q[1], gw_q[2]);
    assign busy       = (state_q != ST_IDLE);
    assign step_done  = (state_q == ST_DONE);
    assign floor_wrap = wrap_q;

endmodule

// File: tb/tb_floor_scroller.sv
// Directed bench for floor_scroller: table of frame steps plus hand-written
// sequences for wrap, re-tick, restart and reset mid-step.
module tb_floor_scroller;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        run;
    logic        restart;
    logic [2:0]  speed;
    logic [29:0] yPos;
    logic [29:0] gapsPos;
    logic [29:0] gapsWidth;
    logic        busy;
    logic        step_done;
    logic        floor_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    floor_scroller #(
        .FLOOR_SPACING (160),
        .MIN_GAP       (48),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .run        (run),
        .restart    (restart),
        .speed      (speed),
        .yPos       (yPos),
        .gapsPos    (gapsPos),
        .gapsWidth  (gapsWidth),
        .busy       (busy),
        .step_done  (step_done),
        .floor_wrap (floor_wrap)
    );

    // Reference LFSR: Fibonacci taps 16,14,13,11, reloaded only by rst.
    logic [15:0] m_lfsr;
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction
    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic int fld(input logic [29:0] bus, input int i);
        return int'(bus[i*10 +: 10]);
    endfunction

    task automatic check_layout(input string tag, input int y0, input int y1, input int y2);
        check({tag, " y0"}, fld(yPos, 0), y0);
        check({tag, " y1"}, fld(yPos, 1), y1);
        check({tag, " y2"}, fld(yPos, 2), y2);
    endtask

    task automatic check_initial(input string tag);
        check({tag, " yPos"},      yPos,      {10'd480, 10'd320, 10'd160});
        check({tag, " gapsPos"},   gapsPos,   {10'd448, 10'd288, 10'd64});
        check({tag, " gapsWidth"}, gapsWidth, {10'd64, 10'd64, 10'd64});
        check({tag, " busy"},      busy,      0);
        check({tag, " step_done"}, step_done, 0);
        check({tag, " floor_wrap"}, floor_wrap, 0);
    endtask

    // Pulse frame_tick in cycle T, then observe cycles T+1..T+6 at negedge.
    task automatic run_step(input logic r, input logic [2:0] s, input int retick_at,
                            output int busy_n, output int done_n, output int done_at,
                            output int wrap_n, output int wrap_at, output logic [15:0] lfsr_m0);
        @(negedge clk);
        frame_tick = 1'b1;
        run        = r;
        speed      = s;
        busy_n = 0; done_n = 0; done_at = -1; wrap_n = 0; wrap_at = -1; lfsr_m0 = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            frame_tick = (i == retick_at);
            if (busy) busy_n++;
            if (step_done) begin done_n++; done_at = i; end
            if (floor_wrap) begin wrap_n++; wrap_at = i; end
            if (i == 1) lfsr_m0 = m_lfsr;
        end
    endtask

    typedef struct {
        logic       run;
        logic [2:0] speed;
        logic       exp_step;
        int         y0, y1, y2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          bn, dn, da, wn, wa, dones;
        logic [15:0] m0;
        int          gw0;

        vecs[0] = '{1'b1, 3'd2, 1'b1, 158, 318, 478};
        vecs[1] = '{1'b0, 3'd5, 1'b0, 158, 318, 478};
        vecs[2] = '{1'b1, 3'd0, 1'b1, 158, 318, 478};
        vecs[3] = '{1'b1, 3'd7, 1'b1, 151, 311, 471};
        vecs[4] = '{1'b1, 3'd3, 1'b1, 148, 308, 468};
        vecs[5] = '{1'b1, 3'd1, 1'b1, 147, 307, 467};

        rst = 1'b1; frame_tick = 1'b0; run = 1'b0; restart = 1'b0; speed = 3'd0;
        repeat (3) @(negedge clk);
        check_initial("reset");
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_step(vecs[v].run, vecs[v].speed, 0, bn, dn, da, wn, wa, m0);
            check_layout($sformatf("vec%0d", v), vecs[v].y0, vecs[v].y1, vecs[v].y2);
            check($sformatf("vec%0d busy_cycles", v), bn, vecs[v].exp_step ? 4 : 0);
            check($sformatf("vec%0d step_done_count", v), dn, vecs[v].exp_step ? 1 : 0);
            check($sformatf("vec%0d step_done_cycle", v), da, vecs[v].exp_step ? 4 : -1);
            check($sformatf("vec%0d floor_wrap_count", v), wn, 0);
        end

        // Second frame_tick at T+2 is ignored: single decrement per floor.
        run_step(1'b1, 3'd1, 2, bn, dn, da, wn, wa, m0);
        check_layout("retick", 146, 306, 466);
        check("retick busy_cycles", bn, 4);
        check("retick step_done_count", dn, 1);

        // restart during MOVE1 aborts the step.
        @(negedge clk);
        frame_tick = 1'b1; run = 1'b1; speed = 3'd2;
        @(negedge clk);
        frame_tick = 1'b0;
        check("restart MOVE0 busy", busy, 1);
        @(negedge clk);
        check("restart MOVE1 y0 moved", fld(yPos, 0), 144);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_initial("restart");
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (step_done) dones++;
        end
        check("restart no late step_done", dones, 0);

        // 80 steps of 2 bring floor0 to y = 0; the next step wraps it.
        for (int k = 0; k < 80; k++) run_step(1'b1, 3'd2, 0, bn, dn, da, wn, wa, m0);
        check_layout("pre_wrap", 0, 160, 320);

        run_step(1'b1, 3'd2, 0, bn, dn, da, wn, wa, m0);
        check_layout("wrap", 478, 158, 318);
        check("wrap floor_wrap_count", wn, 1);
        check("wrap floor_wrap_cycle", wa, 2);
        check("wrap gapPos0", fld(gapsPos, 0), {23'd0, m0[8:0]});
        gw0 = 48 + 4 * int'(m0[13:10]);
        check("wrap gapWidth0", fld(gapsWidth, 0), gw0);
        check("wrap gapWidth0 in range", (fld(gapsWidth, 0) >= 48) && (fld(gapsWidth, 0) <= 108), 1);
        check("wrap gapWidth0 mult4", fld(gapsWidth, 0) % 4, 0);
        check("wrap gapPos1 unchanged", fld(gapsPos, 1), 288);
        check("wrap gapPos2 unchanged", fld(gapsPos, 2), 448);
        check("wrap gapWidth1 unchanged", fld(gapsWidth, 1), 64);

        // rst in the middle of a step.
        @(negedge clk);
        frame_tick = 1'b1; run = 1'b1; speed = 3'd3;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_initial("rst_mid");
        check("rst_mid lfsr seed", dut.u_lfsr.lfsr_q, SEED);
        rst = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (step_done) dones++;
        end
        check("rst_mid no late step_done", dones, 0);

        run_step(1'b1, 3'd4, 0, bn, dn, da, wn, wa, m0);
        check_layout("post_rst", 156, 316, 476);
        check("post_rst step_done_count", dn, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
